// File: rtl/shift_reg_pkg.sv
// Shared encodings for the sequenced shift register: shift modes, directions
// and sequencer states.
package shift_reg_pkg;

  localparam logic [1:0] MODE_SERIAL = 2'b00;
  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_ZERO   = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One single-position shift of a WIDTH-bit word; purely combinational.
// Returns the shifted word and the bit that fell off the end.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic             out_bit_o
);

  logic fill;

  always_comb begin
    out_bit_o = (dir_i == DIR_RIGHT) ? q_i[0] : q_i[WIDTH-1];
    fill      = 1'b0;
    case (mode_i)
      MODE_SERIAL: fill = serial_in_i;
      // Arithmetic left shift fills zero; only right shift replicates the sign.
      MODE_ARITH:  fill = (dir_i == DIR_RIGHT) ? q_i[WIDTH-1] : 1'b0;
      MODE_ROTATE: fill = out_bit_o;
      default:     fill = 1'b0;
    endcase
    if (dir_i == DIR_RIGHT) q_o = {fill, q_i[WIDTH-1:1]};
    else                    q_o = {q_i[WIDTH-2:0], fill};
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Shift register with parallel load and a start/busy/done sequencer that
// performs an amount-long shift one position per clock.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] step_d;
  logic             step_out_d;
  logic             so_q;
  logic             busy_q;
  logic             done_q;
  logic [AMT_W-1:0] count_q;
  logic             dir_q;
  logic [1:0]       mode_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i        (q_q),
    .dir_i      (dir_q),
    .mode_i     (mode_q),
    .serial_in_i(serial_in),
    .q_o        (step_d),
    .out_bit_o  (step_out_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      dir_q   <= DIR_LEFT;
      mode_q  <= MODE_SERIAL;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          q_q     <= step_d;
          so_q    <= step_out_d;
          count_q <= count_q - 1'b1;
          if (count_q == AMT_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        default: begin
          // DONE behaves like IDLE so a new command can follow the pulse directly.
          if (!load_n) begin
            q_q     <= load_val;
            state_q <= ST_IDLE;
          end else if (start && amount == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (start) begin
            count_q <= amount;
            dir_q   <= dir;
            mode_q  <= mode;
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign q           = q_q;
  assign serial_out  = so_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed cases with literal expectations plus a
// random phase, all checked every cycle against a behavioural model.
module tb_shift_reg_seq;
  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_n;
  logic [W-1:0] load_val;
  logic         start;
  logic [A-1:0] amount;
  logic         dir;
  logic [1:0]   mode;
  logic         serial_in;
  logic [W-1:0] q;
  logic         serial_out;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  shift_reg_seq #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .reset_n(reset_n), .load_n(load_n), .load_val(load_val),
    .start(start), .amount(amount), .dir(dir), .mode(mode),
    .serial_in(serial_in), .q(q), .serial_out(serial_out), .busy(busy),
    .done(done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending step count, latched dir/mode, integer shifts.
  int          m_q, m_so, m_left, m_done, m_dir, m_mode;

  function automatic void model_edge();
    int outb, fill;
    if (!reset_n) begin
      m_q = 0; m_so = 0; m_left = 0; m_done = 0;
      return;
    end
    if (m_left > 0) begin
      outb = m_dir ? (m_q & 1) : ((m_q >> (W-1)) & 1);
      case (m_mode)
        0: fill = int'(serial_in);
        1: fill = m_dir ? ((m_q >> (W-1)) & 1) : 0;
        2: fill = outb;
        default: fill = 0;
      endcase
      if (m_dir) m_q = (m_q >> 1) | (fill << (W-1));
      else       m_q = ((m_q << 1) & ((1 << W) - 1)) | fill;
      m_so = outb;
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (!load_n) m_q = int'(load_val);
      else if (start) begin
        if (amount == 0) m_done = 1;
        else begin
          m_left = int'(amount); m_dir = int'(dir); m_mode = int'(mode);
        end
      end
    end
  endfunction

  initial begin
    m_q = 0; m_so = 0; m_left = 0; m_done = 0; m_dir = 0; m_mode = 0;
    forever begin
      @(posedge clk);
      model_edge();
      #1;
      check("model_q", 32'(q), 32'(m_q));
      check("model_serial_out", 32'(serial_out), 32'(m_so));
      check("model_busy", 32'(busy), 32'(m_left > 0));
      check("model_done", 32'(done), 32'(m_done));
    end
  end

  // Launch a shift, then react at each negedge until done (bounded).
  task automatic run_op(input int amt, input logic d, input logic [1:0] m,
                        input logic [15:0] sbits, input bit junk, input bit toggle,
                        output int busy_cnt);
    int i;
    bit fin;
    @(negedge clk);
    start = 1'b1; amount = A'(amt); dir = d; mode = m; load_n = 1'b1;
    busy_cnt = 0; i = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        serial_in = sbits[i];
        i++;
        start    = junk;
        load_n   = !(junk && (cyc % 2 == 0));
        load_val = 8'hFF;
        if (toggle) begin dir = ~dir; mode = mode + 2'd1; end
      end else begin
        start = 1'b0; load_n = 1'b1;
        if (done) fin = 1'b1;
      end
    end
    if (!fin) check("op_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    load_n = 1'b0; load_val = v; start = 1'b0;
    @(negedge clk);
    load_n = 1'b1;
  endtask

  int bc;

  initial begin
    reset_n = 1'b0; load_n = 1'b1; load_val = '0; start = 1'b0;
    amount = '0; dir = 1'b0; mode = 2'b00; serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy_done", 32'({busy, done, serial_out}), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // Load beats start in the same cycle
    @(negedge clk);
    load_n = 1'b0; load_val = 8'hA5; start = 1'b1; amount = 4'd3; mode = 2'b10;
    @(negedge clk);
    check("load_prio_q", 32'(q), 32'hA5);
    check("load_prio_busy_done", 32'({busy, done}), 32'h0);
    load_n = 1'b1; start = 1'b0;

    run_op(3, 1'b0, 2'b10, 16'h0, 1'b0, 1'b0, bc);
    check("rot_busy_cycles", 32'(bc), 32'd3);
    check("rot_q", 32'(q), 32'h2D);
    check("rot_so", 32'(serial_out), 32'd1);

    load(8'h90);
    run_op(2, 1'b1, 2'b01, 16'h0, 1'b0, 1'b1, bc);
    check("arith_busy_cycles", 32'(bc), 32'd2);
    check("arith_q", 32'(q), 32'hE4);
    check("arith_so", 32'(serial_out), 32'd0);

    load(8'h00);
    run_op(4, 1'b0, 2'b00, 16'b1101, 1'b1, 1'b0, bc);
    check("serial_busy_cycles", 32'(bc), 32'd4);
    check("serial_q", 32'(q), 32'h0B);

    // Zero amount, then a new start accepted during the done pulse
    run_op(0, 1'b0, 2'b10, 16'h0, 1'b0, 1'b0, bc);
    check("amt0_busy_cycles", 32'(bc), 32'd0);
    check("amt0_done", 32'(done), 32'd1);
    check("amt0_q", 32'(q), 32'h0B);
    start = 1'b1; amount = 4'd2; dir = 1'b1; mode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_q", 32'(q), 32'h02);

    // Rotate by WIDTH restores the word
    load(8'h3C);
    run_op(8, 1'b1, 2'b10, 16'h0, 1'b0, 1'b0, bc);
    check("rot_width_q", 32'(q), 32'h3C);

    // Reset in the middle of a five-step shift
    load(8'hF1);
    @(negedge clk);
    start = 1'b1; amount = 4'd5; dir = 1'b0; mode = 2'b10;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_q", 32'(q), 32'h0);
    check("midreset_flags", 32'({busy, done, serial_out}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", 32'(dbg_state), 32'h0);
    check("after_reset_busy", 32'(busy), 32'd0);

    // Random traffic, checked by the per-cycle model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      load_n    = ($urandom_range(0, 7) != 0);
      load_val  = W'($urandom);
      start     = ($urandom_range(0, 2) == 0);
      amount    = A'($urandom_range(0, 15));
      dir       = 1'($urandom);
      mode      = 2'($urandom);
      serial_in = 1'($urandom);
    end
    @(negedge clk);
    load_n = 1'b1; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
